// File: rtl/dcache_ctrl_fsm.sv
// Miss-handling controller for a direct-mapped, write-back data cache (4 x 16-bit
// words per line) sitting between the MEM stage and a pipelined four-banked memory.
module dcache_ctrl_fsm #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheReq,
  output logic        CacheHit,
  output logic        Err,
  output logic        c_enable,
  output logic        c_comp,
  output logic        c_write,
  output logic        c_valid_in,
  output logic [4:0]  c_tag,
  output logic [7:0]  c_index,
  output logic [2:0]  c_offset,
  output logic [15:0] c_data_in,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic [4:0]  c_tag_out,
  input  logic [15:0] c_data_out,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [15:0] m_data_out,
  input  logic        m_stall
);

  typedef enum logic [2:0] {IDLE, WRITEBACK, ALLOCATE, FILL, RETRY} state_t;

  state_t      state, state_nxt;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        req_rd;
  logic [1:0]  word_cnt;
  logic [1:0]  fill_cnt;
  logic        pipe_vld [MEM_LAT];
  logic [1:0]  pipe_off [MEM_LAT];

  logic        req_valid, req_err;
  logic        latch_req, word_inc, rd_accept, fill_wr;

  assign req_valid = (Rd ^ Wr) && !Addr[0];
  assign req_err   = (Rd || Wr) && (Addr[0] || (Rd && Wr));
  assign fill_wr   = pipe_vld[MEM_LAT-1] && (state == ALLOCATE || state == FILL);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= 2'd0;
      fill_cnt <= 2'd0;
      for (int i = 0; i < MEM_LAT; i++) pipe_vld[i] <= 1'b0;
    end else begin
      state <= state_nxt;
      if (word_inc) word_cnt <= word_cnt + 2'd1;
      if (fill_wr)  fill_cnt <= fill_cnt + 2'd1;
      pipe_vld[0] <= rd_accept;
      pipe_off[0] <= word_cnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_off[i] <= pipe_off[i-1];
      end
    end
  end

  // NOTE: payload registers (latched request, pipe offsets) are deliberately not
  // reset; they are only consumed under a state or valid bit that reset does clear.
  always_ff @(posedge clk) begin
    if (latch_req) begin
      req_addr <= Addr;
      req_data <= DataIn;
      req_rd   <= Rd;
    end
  end

  // NOTE: every output and internal control gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt  = state;
    latch_req  = 1'b0;
    word_inc   = 1'b0;
    rd_accept  = 1'b0;
    DataOut    = 16'h0;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheReq   = 1'b0;
    CacheHit   = 1'b0;
    Err        = 1'b0;
    c_enable   = 1'b0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_valid_in = 1'b0;
    c_tag      = 5'h0;
    c_index    = 8'h0;
    c_offset   = 3'h0;
    c_data_in  = 16'h0;
    m_addr     = 16'h0;
    m_data_in  = 16'h0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;

    // Outputs are held quiet for the whole reset cycle, whatever the state.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_err) begin
            Done = 1'b1;
            Err  = 1'b1;
          end else if (req_valid) begin
            CacheReq  = 1'b1;
            c_enable  = 1'b1;
            c_comp    = 1'b1;
            c_write   = Wr;
            c_tag     = Addr[15:11];
            c_index   = Addr[10:3];
            c_offset  = Addr[2:0];
            c_data_in = DataIn;
            if (c_hit && c_valid) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = Rd ? c_data_out : 16'h0;
            end else begin
              Stall     = 1'b1;
              latch_req = 1'b1;
              state_nxt = (c_valid && c_dirty) ? WRITEBACK : ALLOCATE;
            end
          end
        end

        WRITEBACK: begin
          Stall     = 1'b1;
          c_enable  = 1'b1;
          c_tag     = req_addr[15:11];
          c_index   = req_addr[10:3];
          c_offset  = {word_cnt, 1'b0};
          m_wr      = 1'b1;
          m_addr    = {c_tag_out, req_addr[10:3], word_cnt, 1'b0};
          m_data_in = c_data_out;
          if (!m_stall) begin
            word_inc = 1'b1;
            if (word_cnt == 2'd3) state_nxt = ALLOCATE;
          end
        end

        ALLOCATE: begin
          Stall  = 1'b1;
          m_rd   = 1'b1;
          m_addr = {req_addr[15:3], word_cnt, 1'b0};
          if (!m_stall) begin
            rd_accept = 1'b1;
            word_inc  = 1'b1;
            if (word_cnt == 2'd3) state_nxt = FILL;
          end
        end

        FILL: begin
          Stall = 1'b1;
          if (fill_wr && fill_cnt == 2'd3) state_nxt = RETRY;
        end

        RETRY: begin
          c_enable  = 1'b1;
          c_comp    = 1'b1;
          c_write   = !req_rd;
          c_tag     = req_addr[15:11];
          c_index   = req_addr[10:3];
          c_offset  = req_addr[2:0];
          c_data_in = req_data;
          Done      = 1'b1;
          DataOut   = req_rd ? c_data_out : 16'h0;
          state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase

      // Returning memory words are written straight into the line as they arrive.
      if (fill_wr) begin
        c_enable   = 1'b1;
        c_comp     = 1'b0;
        c_write    = 1'b1;
        c_valid_in = 1'b1;
        c_tag      = req_addr[15:11];
        c_index    = req_addr[10:3];
        c_offset   = {pipe_off[MEM_LAT-1], 1'b0};
        c_data_in  = m_data_out;
      end
    end
  end

endmodule
